// File: rtl/ddfs_mix_pkg.sv
// Shared constants and helpers for the multi-channel DDFS mixer slot.
package ddfs_mix_pkg;

    // Per-channel register offsets (addr = 4*ch + offset)
    localparam logic [1:0] REG_FCCW = 2'd0;
    localparam logic [1:0] REG_FOCW = 2'd1;
    localparam logic [1:0] REG_PHA  = 2'd2;
    localparam logic [1:0] REG_ENV  = 2'd3;

    // Global register addresses
    localparam logic [4:0] ADDR_CTRL = 5'd16;
    localparam logic [4:0] ADDR_PCM  = 5'd17;
    localparam logic [4:0] ADDR_CNT  = 5'd18;

    localparam int          CTRL_MODE_BIT = 8;
    localparam logic [15:0] ENV_ONE       = 16'h4000;

    typedef enum logic {
        MIX_SUM = 1'b0,   // saturating sum of all channels
        MIX_AVG = 1'b1    // sum scaled down by ceil(log2(NCH))
    } mix_mode_e;

    // Clamp a signed value into the 16-bit PCM range.
    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7fff;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/ddfs_mix_io_dac.sv
// First-order sigma-delta 1-bit DAC for a signed W-bit PCM input.
module pdm_dac #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] i_pcm,
    output logic                o_pdm
);

    logic [W-1:0] w_offset;
    logic [W:0]   r_acc;

    // Convert two's complement to offset binary so mid-scale gives 50% density.
    assign w_offset = {~i_pcm[W-1], i_pcm[W-2:0]};

    // Error accumulator; its carry out is the pulse stream.
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else
            r_acc <= {1'b0, r_acc[W-1:0]} + {1'b0, w_offset};
    end

    assign o_pdm = r_acc[W];

endmodule

// File: rtl/ddfs_mix_io_sin_lut.sv
// Full-wave sine ROM with a registered output; entry i = round(32767*sin(2*pi*i/2^LW)).
module sin_lut #(
    parameter int LW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LW-1:0]        i_addr,
    output logic signed [15:0]   o_data
);

    // Constant table, built at elaboration time.
    logic signed [15:0] w_rom [2**LW];

    for (genvar i = 0; i < 2**LW; i++) begin : g_rom
        localparam real ANG  = 6.283185307179586 * real'(i) / real'(2**LW);
        localparam real VAL  = 32767.0 * $sin(ANG);
        localparam int  IVAL = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
        assign w_rom[i] = 16'(IVAL);
    end

    // Registered ROM read.
    // NOTE: only the output register is reset; the table itself is constant
    // logic, and resetting a memory array would stop it mapping onto ROM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_data <= '0;
        else
            o_data <= w_rom[i_addr];
    end

endmodule

// File: rtl/ddfs_mix_io.sv
// Multi-channel time-multiplexed DDFS slot: shared phase/LUT/envelope pipeline,
// per-frame mixer, PCM output and PDM DAC, on a 5-bit-address MMIO slot.
module ddfs_mix_io
    import ddfs_mix_pkg::*;
#(
    parameter int PW    = 30,
    parameter int LW    = 10,
    parameter int NCH   = 4,
    parameter int FRAME = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                read,
    input  logic                write,
    input  logic [4:0]          addr,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                digital_out,
    output logic                pdm_out,
    output logic signed [15:0]  pcm_out,
    output logic                sample_tick
);

    localparam int SW = $clog2(FRAME);
    localparam int SH = $clog2(NCH);

    // Register file
    logic [PW-1:0]      r_fccw  [NCH];
    logic [PW-1:0]      r_focw  [NCH];
    logic [PW-1:0]      r_pha   [NCH];
    logic [15:0]        r_env   [NCH];
    logic [NCH-1:0]     r_mask;
    mix_mode_e          r_mode;

    // Frame-synchronous copies of ctrl, captured at slot 0
    logic [NCH-1:0]     r_mask_frame;
    mix_mode_e          r_mode_frame;

    // Datapath state
    logic [PW-1:0]      r_phase [NCH];
    logic [SW-1:0]      r_slot;
    logic               r_s1_en;
    logic signed [15:0] r_s1_env;
    logic signed [15:0] r_s2_val;
    logic signed [17:0] r_acc;
    logic signed [15:0] r_pcm;
    logic               r_tick;
    logic [31:0]        r_cnt;

    // Wires
    logic               w_wr;
    logic               w_ch_wr;
    logic [1:0]         w_wr_ch;
    logic               w_issue;
    logic [1:0]         w_ch;
    logic [NCH-1:0]     w_mask_now;
    logic               w_ch_en;
    logic [PW-1:0]      w_lut_sum;
    logic [LW-1:0]      w_lut_addr;
    logic signed [15:0] w_sin;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_scaled;
    logic               w_frame_end;
    logic signed [17:0] w_avg;
    logic signed [15:0] w_mix;
    logic               w_unused;

    // ---------------------------------------------------------------- decode
    assign w_wr    = cs & write;
    assign w_wr_ch = addr[3:2];
    assign w_ch_wr = w_wr & ~addr[4] & (int'(w_wr_ch) < NCH);

    assign w_ch        = r_slot[1:0];
    assign w_issue     = int'(r_slot) < NCH;
    assign w_frame_end = (r_slot == SW'(NCH + 2));

    // A ctrl write lands in the frame-synchronous copy only at slot 0.
    assign w_mask_now = (r_slot == '0) ? r_mask : r_mask_frame;
    assign w_ch_en    = w_issue & w_mask_now[w_ch];

    assign w_lut_sum  = r_phase[w_ch] + r_pha[w_ch];
    assign w_lut_addr = w_lut_sum[PW-1 -: LW];

    assign w_prod   = w_sin * r_s1_env;
    assign w_scaled = w_prod >>> 14;

    assign w_avg = r_acc >>> SH;
    assign w_mix = (r_mode_frame == MIX_AVG) ? w_avg[15:0]
                                             : sat16({{14{r_acc[17]}}, r_acc});

    // Bits deliberately left unconsumed by the datapath.
    assign w_unused = ^{write_data, w_lut_sum, w_avg, w_scaled[31:16]};

    // Per-channel parameter registers, written from the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_fccw[c] <= '0;
                r_focw[c] <= '0;
                r_pha[c]  <= '0;
                r_env[c]  <= ENV_ONE;
            end
        end else if (w_ch_wr) begin
            case (addr[1:0])
                REG_FCCW: r_fccw[w_wr_ch] <= write_data[PW-1:0];
                REG_FOCW: r_focw[w_wr_ch] <= write_data[PW-1:0];
                REG_PHA:  r_pha[w_wr_ch]  <= write_data[PW-1:0];
                REG_ENV:  r_env[w_wr_ch]  <= write_data[15:0];
                default:  ;
            endcase
        end
    end

    // Control register: enable mask and mix mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= NCH'(1);
            r_mode <= MIX_SUM;
        end else if (w_wr && addr == ADDR_CTRL) begin
            r_mask <= write_data[NCH-1:0];
            r_mode <= mix_mode_e'(write_data[CTRL_MODE_BIT]);
        end
    end

    // Slot counter and frame-start capture of ctrl.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot       <= '0;
            r_mask_frame <= NCH'(1);
            r_mode_frame <= MIX_SUM;
        end else begin
            r_slot <= (r_slot == SW'(FRAME - 1)) ? '0 : r_slot + 1'b1;
            if (r_slot == '0) begin
                r_mask_frame <= r_mask;
                r_mode_frame <= r_mode;
            end
        end
    end

    // S0: advance the issued channel's phase; disabled channels park at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++)
                r_phase[c] <= '0;
        end else if (w_issue) begin
            r_phase[w_ch] <= w_ch_en ? (r_phase[w_ch] + r_fccw[w_ch] + r_focw[w_ch]) : '0;
        end
    end

    // S0 -> S1: carry the enable and envelope alongside the ROM lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_en  <= 1'b0;
            r_s1_env <= '0;
        end else begin
            r_s1_en  <= w_ch_en;
            r_s1_env <= r_env[w_ch];
        end
    end

    sin_lut #(.LW(LW)) u_sin_lut (
        .clk    (clk),
        .rst    (rst),
        .i_addr (w_lut_addr),
        .o_data (w_sin)
    );

    // S2: envelope scaling back to Q0.15 with saturation; idle slots give 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_s2_val <= '0;
        else
            r_s2_val <= r_s1_en ? sat16(w_scaled) : '0;
    end

    // S3: frame accumulator, cleared at slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (r_slot == '0)
            r_acc <= '0;
        else
            r_acc <= r_acc + {{2{r_s2_val[15]}}, r_s2_val};
    end

    // Frame end: register the mixed sample, pulse the tick, bump the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcm  <= '0;
            r_tick <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_tick <= w_frame_end;
            if (w_frame_end) begin
                r_pcm <= w_mix;
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Combinational read mux; unmapped addresses read zero.
    // NOTE: read_data gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        read_data = '0;
        if (cs && read) begin
            if (!addr[4]) begin
                if (int'(w_wr_ch) < NCH) begin
                    case (addr[1:0])
                        REG_FCCW: read_data = 32'(r_fccw[w_wr_ch]);
                        REG_FOCW: read_data = 32'(r_focw[w_wr_ch]);
                        REG_PHA:  read_data = 32'(r_pha[w_wr_ch]);
                        REG_ENV:  read_data = {16'h0000, r_env[w_wr_ch]};
                        default:  read_data = '0;
                    endcase
                end
            end else begin
                case (addr)
                    ADDR_CTRL: read_data = 32'(r_mask) | (32'(r_mode) << CTRL_MODE_BIT);
                    ADDR_PCM:  read_data = {16'h0000, r_pcm};
                    ADDR_CNT:  read_data = r_cnt;
                    default:   read_data = '0;
                endcase
            end
        end
    end

    pdm_dac #(.W(16)) u_dac (
        .clk   (clk),
        .rst   (rst),
        .i_pcm (r_pcm),
        .o_pdm (pdm_out)
    );

    assign pcm_out     = r_pcm;
    assign sample_tick = r_tick;
    assign digital_out = r_phase[0][PW-1];

endmodule

// File: doc/ddfs_mix_io.md
Name: ddfs_mix_io

Overview:
- Multi-channel DDFS slot core: NCH time-multiplexed DDFS channels share one phase/LUT/envelope pipeline.
- Channel outputs are mixed into one 16-bit PCM sample per frame, then fed to a 1-bit PDM DAC.
- Sits on a standard 5-bit-address MMIO slot, in the same position as the single-channel DDFS slot it supersedes.

Parameters:
- PW, 30, phase accumulator width; PW >= 12.
- LW, 10, sine LUT address width; the LUT has 2^LW entries.
- NCH, 4, channel count; legal range 1..4.
- FRAME, 8, clocks per output sample; must satisfy FRAME >= NCH+3.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cs  in  1  slot select
- read  in  1  read strobe; reads are side-effect free
- write  in  1  write strobe
- addr  in  5  register address
- write_data  in  32  write data
- read_data  out  32  combinational read mux
- digital_out  out  1  square wave = MSB of channel 0 phase
- pdm_out  out  1  1-bit DAC output
- pcm_out  out  16  mixed signed sample
- sample_tick  out  1  one-cycle pulse when pcm_out updates

Behaviour:
- Register map:
  - addr = 4*ch+r for ch < NCH: r0 fccw, r1 focw, r2 pha (each PW bits), r3 env (16-bit Q2.14).
  - addr 16 ctrl: bits[NCH-1:0] channel enable mask; bit 8 mix mode (0 = saturating sum, 1 = average).
  - addr 17 pcm (read-only).
  - addr 18 sample count (read-only, 32-bit, wraps).
- Write = cs & write & address match; writes to read-only or unmapped addresses are ignored.
- Reads return zero-extended fields; unmapped addresses read 0.
- Reset values:
  - fccw/focw/pha/phase accumulators 0; env 0x4000 (1.0); ctrl 0x001 (ch0 enabled, sum mode).
  - pcm_out 0, sample count 0, slot counter 0, sample_tick 0, digital_out 0.
- Slot counter: runs 0..FRAME-1 and wraps; slot s < NCH issues channel s.
- Pipeline per issued channel:
  - S0: registers sampled; phase_acc[ch] <= phase_acc + fccw + focw (mod 2^PW); LUT index = (phase_acc + pha)[PW-1:PW-LW], using the pre-update phase.
  - S1: registered ROM output, signed 16-bit, entry i = round(32767*sin(2*pi*i/2^LW)).
  - S2: signed product sin*env (32-bit); take bits [29:14]; saturate to [-32768, 32767].
  - S3: accumulate into a (16+2)-bit signed accumulator, cleared at slot 0.
  - A disabled channel contributes 0 and its phase_acc is held at 0, so re-enabling restarts at phase 0.
- Frame end, at slot NCH+2:
  - Mode 0: saturate the accumulator to 16 bits.
  - Mode 1: arithmetic shift right by ceil(log2(NCH)).
  - The result registers into pcm_out at that clock edge; sample_tick is high for the following cycle; sample count increments.
- A register write in a channel's issue cycle is not seen until the next frame.
- A ctrl write mid-frame takes effect at the next slot 0.
- Reset mid-frame: everything returns immediately to reset values; no partial sample is emitted.

Decomposition:
- Package ddfs_mix_pkg holds:
  - Register offset constants (REG_FCCW..REG_ENV, ADDR_CTRL=16, ADDR_PCM=17, ADDR_CNT=18).
  - CTRL_MODE_BIT=8, ENV_ONE=16'h4000.
  - A sat16 function.
- Sub-module sin_lut (LW-addressed registered ROM).
- Reuse the existing DAC (W=16) for pdm_out.

Test Plan:
- Reset -> pcm_out=0, sample_tick=0, addr3 reads 0x4000, addr16 reads 0x1, addr18 reads 0; sample_tick pulses exactly every 8 clocks thereafter.
- NCH=4, ch0 fccw=2^28, env 0x4000 -> successive pcm_out 0, 32767, 0, -32767, repeating; addr18 increments per tick.
- Same setup, env 0x2000 -> pcm_out 0, 16383, 0, -16384 (bit-slice truncation of the negative product).
- ch0 and ch1 both pha=2^28, fccw=0, enabled mask 0x3:
  - Mode 0 -> pcm_out 32767 (saturated).
  - Mode 1 -> 16383.
- Disable ch0 mid-stream -> next frame pcm_out 0 and ch0 phase 0; re-enable -> sequence restarts at 0, 32767.
- Assert rst at slot 5 with accumulator nonzero -> pcm_out=0 immediately; first tick 8 clocks after release; ignored write to addr 17 leaves pcm unchanged.
